// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_pkg;

  // Processor-side bus command; 2'b11 is decoded as no access.
  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_t;

  // RV32I load/store width encodings carried in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a word-wide memory: byte enables, store-data
// replication and misalignment detection for the access being launched,
// and extraction/extension of load data for the access in flight.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] ld_shift;

  // Lane enables and store replication; unknown widths behave as a word.
  always_comb begin
    be_o       = 4'hF;
    wdata_o    = st_data_i;
    misalign_o = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << st_off_i;
        wdata_o    = {2{st_data_i[15:0]}};
        misalign_o = st_off_i[0];
      end
      F3_W:    misalign_o = (st_off_i != 2'b00);
      default: misalign_o = (st_off_i != 2'b00);
    endcase
  end

  assign ld_shift = ld_data_i >> {ld_off_i, 3'b000};

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    rdata_o = ld_data_i;
    case (ld_funct3_i)
      F3_B:    rdata_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   rdata_o = {24'h0, ld_shift[7:0]};
      F3_H:    rdata_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   rdata_o = {16'h0, ld_shift[15:0]};
      default: rdata_o = ld_data_i;
    endcase
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: converts the per-cycle MEM-stage command into
// one req/ack transaction, stalls the pipeline until it completes, and
// returns aligned load data (or a fault with zero data) in the DONE cycle.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem2proc_data,
  output logic        dmem_stall,
  output logic        dmem_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      result_q, result_d;
  logic             fault_q, fault_d;

  logic             access;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic             lane_misalign;
  logic [31:0]      lane_rdata;

  assign access = (proc2Dmem_command == BUS_LOAD) || (proc2Dmem_command == BUS_STORE);

  dmem_lane_align u_align (
    .st_funct3_i (mem_funct3),
    .st_off_i    (proc2Dmem_addr[1:0]),
    .st_data_i   (proc2mem_data),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_data_i   (mem_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .misalign_o  (lane_misalign),
    .rdata_o     (lane_rdata)
  );

  // Next-state, timeout counter and transaction register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    result_d = result_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access) begin
          we_d     = (proc2Dmem_command == BUS_STORE);
          addr_d   = {proc2Dmem_addr[31:2], 2'b00};
          be_d     = lane_be;
          wdata_d  = lane_wdata;
          f3_d     = mem_funct3;
          off_d    = proc2Dmem_addr[1:0];
          result_d = '0;
          // A misaligned access never reaches memory; it completes as a fault.
          fault_d  = lane_misalign;
          state_d  = lane_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          result_d = we_q ? 32'h0 : lane_rdata;
          state_d  = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d  = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // The command still visible here is the one just completed.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      result_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      result_q <= result_d;
      fault_q  <= fault_d;
    end
  end

  assign mem_req       = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign dmem_stall    = ((state_q == IDLE) && access) || (state_q == REQ);
  assign dmem_fault    = (state_q == DONE) && fault_q;
  assign mem2proc_data = (state_q == DONE) ? result_q : 32'h0;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: a driver issues transactions and acts as the
// memory, pushing the expected outcome of each into a queue; an independent
// monitor pops and compares whenever the controller releases the stall.
module tb_dmem_bus_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2mem_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem2proc_data;
  logic        dmem_stall;
  logic        dmem_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem_funct3        (mem_funct3),
    .mem2proc_data     (mem2proc_data),
    .dmem_stall        (dmem_stall),
    .dmem_fault        (dmem_fault),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_be            (mem_be),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    bit          fault;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   leak   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Expected outcome from the access rules: width in bytes, offset, lanes.
  function automatic exp_t model(input logic [1:0] cmd, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int delay);
    exp_t e;
    int k, size;
    logic [31:0] mask, v;
    e = '{default: 0};
    k = int'(addr[1:0]);
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    if (k % size != 0) begin
      e.fault  = 1;
      e.stalls = 1;
      return e;
    end
    e.req  = 1;
    e.addr = addr & 32'hFFFF_FFFC;
    e.we   = (cmd == 2'b10);
    e.be   = 4'(((1 << size) - 1) << k);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(wd >> (8 * (i % size)));
    if (delay == 0) begin
      e.fault  = 1;
      e.stalls = 1 + TIMEOUT;
    end else begin
      e.stalls = 1 + delay;
    end
    if (!e.we && delay != 0) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      v = (rd >> (8 * k)) & mask;
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8*size-1]) v = v | ~mask;
      e.data = v;
    end
    return e;
  endfunction

  // Issue one access and play memory; delay = req cycle carrying ack, 0 = never.
  // Entered and left just after a rising edge, with the DUT in IDLE.
  task automatic do_txn(input logic [1:0] cmd, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay);
    int reqc;
    bit done;
    exp_q.push_back(model(cmd, f3, addr, wd, rd, delay));
    proc2Dmem_command = cmd;
    mem_funct3        = f3;
    proc2Dmem_addr    = addr;
    proc2mem_data     = wd;
    reqc = 0;
    done = 0;
    for (int cyc = 0; cyc < TIMEOUT + 20 && !done; cyc++) begin
      @(negedge clk);
      if (!dmem_stall) done = 1;
      else if (mem_req) begin
        reqc++;
        mem_rdata = $urandom;
        if (delay != 0 && reqc == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    chk("txn_completes", 32'(done), 32'd1);
  endtask

  // One idle cycle with an optional stray ack; the DUT must stay quiet.
  task automatic idle_cycle(input logic [1:0] cmd, input bit ack);
    proc2Dmem_command = cmd;
    @(negedge clk);
    mem_ack   = ack;
    mem_rdata = $urandom;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  // Monitor: tracks stall runs and requests, compares on each stall release.
  initial begin
    int   stall_cnt = 0, req_rise = 0;
    bit   prev_stall = 0, prev_req = 0, unstable = 0;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0; req_rise = 0; unstable = 0; prev_stall = 0; prev_req = 0;
      end else begin
        if (prev_stall && !dmem_stall) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_release", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("load_data", mem2proc_data, e.data);
            chk("fault_pulse", 32'(dmem_fault), 32'(e.fault));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            chk("request_count", 32'(req_rise), 32'(e.req));
            if (e.req) begin
              chk("mem_addr", c_addr, e.addr);
              chk("mem_we", 32'(c_we), 32'(e.we));
              chk("mem_be", 32'(c_be), 32'(e.be));
              if (e.we) chk("mem_wdata", c_wdata, e.wdata);
              chk("req_stable", 32'(unstable), 32'd0);
            end
          end
          stall_cnt = 0; req_rise = 0; unstable = 0;
        end else if (dmem_fault || mem2proc_data != 32'h0) begin
          leak = 1;
        end
        if (dmem_stall) stall_cnt++;
        if (mem_req && !prev_req) begin
          req_rise++;
          c_addr = mem_addr; c_we = mem_we; c_be = mem_be; c_wdata = mem_wdata;
        end else if (mem_req && (mem_addr !== c_addr || mem_we !== c_we ||
                                 mem_be !== c_be || mem_wdata !== c_wdata)) begin
          unstable = 1;
        end
        prev_stall = dmem_stall;
        prev_req   = mem_req;
      end
    end
  end

  // Driver.
  initial begin
    logic [1:0] cmd;
    int         gap;
    rst = 1'b1; proc2Dmem_command = 2'b00; proc2Dmem_addr = '0; proc2mem_data = '0;
    mem_funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(dmem_stall), 32'd0);
    chk("rst_fault", 32'(dmem_fault), 32'd0);
    chk("rst_data", mem2proc_data, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle(2'b00, 1'b0);

    // Directed cases.
    do_txn(2'b01, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
    idle_cycle(2'b00, 1'b0);
    do_txn(2'b01, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 5);
    idle_cycle(2'b00, 1'b0);
    do_txn(2'b01, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 5);
    idle_cycle(2'b00, 1'b0);
    do_txn(2'b10, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 2);
    idle_cycle(2'b00, 1'b0);
    do_txn(2'b01, 3'b010, 32'h0000_0101, 32'h0, 32'h1234_5678, 1);
    idle_cycle(2'b00, 1'b0);
    do_txn(2'b01, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 0);
    idle_cycle(2'b00, 1'b1);
    // Back-to-back load then store, no gap.
    do_txn(2'b01, 3'b001, 32'h0000_0412, 32'h0, 32'h7FFF_8001, 3);
    do_txn(2'b10, 3'b000, 32'h0000_0501, 32'h0000_005A, 32'h0, 1);
    idle_cycle(2'b00, 1'b0);

    // Reset while a request is outstanding.
    proc2Dmem_command = 2'b01; mem_funct3 = 3'b010; proc2Dmem_addr = 32'h0000_0600;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("req_before_rst", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; proc2Dmem_command = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_req_mem_req", 32'(mem_req), 32'd0);
    chk("rst_in_req_stall", 32'(dmem_stall), 32'd0);
    chk("rst_in_req_fault", 32'(dmem_fault), 32'd0);
    @(posedge clk); #1;
    idle_cycle(2'b11, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      cmd = 2'($urandom_range(1, 2));
      do_txn(cmd, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 6)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        idle_cycle($urandom_range(0, 1) ? 2'b11 : 2'b00, 1'($urandom_range(0, 1)));
    end

    proc2Dmem_command = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("quiet_outside_done", 32'(leak), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
